param_burst_mem_mc: RTL
=======================

// Module: param_burst_mem_mc
// PURPOSE
// Multi-channel, parametrised burst memory used as physical memory behind the cache hierarchy.
// NUM_CH requesters (e.g. I-cache, D-cache) share one line-wide storage array through a round-robin arbiter.
// Latency depends on DRAM-style open-page tracking; each line is moved as BURST_LEN beats.
// Protocol violations are reported per channel with a sticky error flag.
// PARAMETERS
// NUM_CH          2     number of requester channels (1..8)
// DELAY_MEM       10    cycles from accept to first beat on page miss (>=1)
// DELAY_PAGE_HIT  3     cycles from accept to first beat on page hit (>=1)
// BURST_LEN       4     beats per line
// LINE_WIDTH      256   line width in bits; must be divisible by BURST_LEN
// PAGE_SIZE       4096  page size in bytes, power of two
// DEPTH           1024  lines of storage, power of two
// INIT_FILE       ""    $readmemh image loaded at elaboration if non-empty
// PORTS
// clk       in   1                            clock, all state on rising edge
// rst_n     in   1                            asynchronous, active-low reset
// read      in   NUM_CH                       per-channel read request, held until burst completes
// write     in   NUM_CH                       per-channel write request, held until burst completes
// addr      in   NUM_CH*32                    per-channel byte address, channel c at [32*c +: 32]
// wdata     in   NUM_CH*(LINE_WIDTH/BURST_LEN) per-channel write beat
// rdata     out  LINE_WIDTH/BURST_LEN         shared read beat, valid when any resp bit is high
// resp      out  NUM_CH                       per-channel beat strobe, at most one bit high
// error     out  NUM_CH                       per-channel sticky protocol error
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; resp=0; rdata=0; error=0; open-page valid=0; RR pointer=0.
//   Storage contents are NOT cleared by reset.
// - Addressing:
//   line index = addr[OFF +: log2(DEPTH)], OFF = log2(LINE_WIDTH/8); higher bits are ignored (wraps).
//   page = addr/PAGE_SIZE.
// - States: IDLE -> WAIT -> BURST -> TURN -> IDLE.
// - IDLE:
//   - A channel is eligible if (read^write)=1 and its error=0.
//   - A channel with read&write both high sets its error bit and is not granted.
//   - Grant goes to the first eligible channel at or after the RR pointer.
//   - On grant: latch channel, op, and addr; delay = DELAY_PAGE_HIT if open page is valid and equals the request page,
//     else DELAY_MEM; load open page, set it valid, and go to WAIT.
// - WAIT: count down. The first beat's cycle begins exactly `delay` edges after the accept edge, then BURST.
// - BURST: resp[g]=1 for BURST_LEN consecutive cycles, beat i = 0..BURST_LEN-1, lowest beat first.
//   - Read: rdata = line[BW*i +: BW] in the same cycle as resp.
//   - Write: wdata[g] is captured into line[BW*i +: BW] at the edge ending beat i.
//   - After the last beat go to TURN; RR pointer = g+1 mod NUM_CH.
// - TURN: one cycle with resp=0 and requests ignored. This lets registered requesters drop read/write.
// - Checks each cycle in WAIT/BURST on granted channel g:
//   - read/write no longer matches the latched op, the opposite op is asserted, or addr changed.
//   - On any violation: set error[g], clear resp, clear open-page valid, go to IDLE with no further writes.
//   - Beats already written remain in storage.
// - Ungranted channels may hold requests indefinitely; they are never errored for waiting.
// - error[c] clears only on reset; an errored channel is never granted.
// - Reset asserted mid-burst: immediate IDLE; storage keeps beats already written.
// - Combinational paths: none from inputs to outputs. resp and rdata are registered.
// TESTING
// 1. Read after reset, ch0 addr 0x100, INIT_FILE line 8 = known pattern.
//    -> first resp at accept+10; 4 resp cycles; beats = pattern[63:0], [127:64], [191:128], [255:192].
// 2. Page hit: ch0 reads 0x100 then 0x140.
//    -> second burst starts accept+3. Then 0x1100 -> accept+10 (miss).
// 3. Write then read, ch1 addr 0x2000, beats 0xA0..0xA3.
//    -> subsequent read returns the same 4 beats; other lines unchanged.
// 4. Contention: ch0 and ch1 request in the same cycle, RR=0.
//    -> ch0 is served first, TURN, then ch1; resp never high on both channels; next tie goes to ch0 after ch1.
// 5. Violation: ch0 read 0x100, addr changed to 0x104 in WAIT.
//    -> error[0]=1 next edge, no resp, ch0 ignored afterwards, ch1 still served; rst_n low clears error[0].
// 6. Wrap and reset: read at addr DEPTH*32+0x20 returns line 1. rst_n pulsed mid-write after beat 1.
//    -> resp=0 at once; beats 0..1 updated, beats 2..3 old.

Source files
------------

// File: rtl/param_burst_mem_mc.sv
// param_burst_mem_mc
// Multi-channel burst memory that sits behind the cache hierarchy as physical
// memory. NUM_CH requesters share one line-wide storage array through a
// round-robin arbiter. Each line moves as BURST_LEN beats, lowest beat first.
// The first-beat latency is DELAY_PAGE_HIT when the request falls in the
// currently open page, and DELAY_MEM otherwise. A requester that breaks the
// handshake gets a sticky error bit and is never served again until reset.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset (storage contents are kept)
//   read   : per-channel read request, held until the burst completes
//   write  : per-channel write request, held until the burst completes
//   addr   : per-channel byte address, channel c at [32*c +: 32]
//   wdata  : per-channel write beat, channel c at [BW*c +: BW]
//   rdata  : shared read beat, valid while any resp bit is high
//   resp   : per-channel beat strobe, at most one bit high
//   error  : per-channel sticky protocol error
`timescale 1ns/1ps
module param_burst_mem_mc #(
    parameter int    NUM_CH         = 2,
    parameter int    DELAY_MEM      = 10,
    parameter int    DELAY_PAGE_HIT = 3,
    parameter int    BURST_LEN      = 4,
    parameter int    LINE_WIDTH     = 256,
    parameter int    PAGE_SIZE      = 4096,
    parameter int    DEPTH          = 1024,
    parameter string INIT_FILE      = ""
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CH-1:0]                        read,
    input  logic [NUM_CH-1:0]                        write,
    input  logic [NUM_CH*32-1:0]                     addr,
    input  logic [NUM_CH*(LINE_WIDTH/BURST_LEN)-1:0] wdata,
    output logic [LINE_WIDTH/BURST_LEN-1:0]          rdata,
    output logic [NUM_CH-1:0]                        resp,
    output logic [NUM_CH-1:0]                        error
);

    localparam int BW     = LINE_WIDTH / BURST_LEN;
    localparam int OFF    = $clog2(LINE_WIDTH / 8);
    localparam int LIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PG_SH  = $clog2(PAGE_SIZE);
    localparam int PG_W   = 32 - PG_SH;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int DMAX   = (DELAY_MEM > DELAY_PAGE_HIT) ? DELAY_MEM : DELAY_PAGE_HIT;
    localparam int CNT_W  = $clog2(DMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        TURN
    } state_t;

    logic [LINE_WIDTH-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CH_W-1:0]     gch_q, gch_d;
    logic                opw_q, opw_d;
    logic [31:0]         addr_q, addr_d;
    logic [PG_W-1:0]     page_q, page_d;
    logic                page_vld_q, page_vld_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0]   error_q, error_d;
    logic [NUM_CH-1:0]   resp_q, resp_d;
    logic [BW-1:0]       rdata_q, rdata_d;

    logic                found;
    logic [CH_W-1:0]     cand;
    logic [CH_W-1:0]     pick;
    logic [31:0]         req_addr;
    logic [PG_W-1:0]     req_page;
    logic [BEAT_W-1:0]   rd_beat;
    logic                mem_we;

    logic [31:0]         cur_addr;
    logic                viol;
    logic [LIDX_W-1:0]   line_idx;
    logic [LINE_WIDTH-1:0] line_rd;
    logic [BW-1:0]       wbeat;

    assign cur_addr = addr[int'(gch_q)*32 +: 32];
    assign wbeat    = wdata[int'(gch_q)*BW +: BW];
    assign line_idx = addr_q[OFF +: LIDX_W];
    assign line_rd  = mem[line_idx];

    // The granted channel must keep exactly the latched op and address for
    // the whole transaction; anything else aborts it.
    assign viol = (read[gch_q] == opw_q) || (write[gch_q] != opw_q) || (cur_addr != addr_q);

    assign rdata = rdata_q;
    assign resp  = resp_q;
    assign error = error_q;

    // Storage write port: one beat per cycle during a clean write burst.
    // No reset here, so beats already written survive a reset mid-burst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[line_idx][int'(beat_q)*BW +: BW] <= wbeat;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            gch_q      <= '0;
            opw_q      <= 1'b0;
            addr_q     <= '0;
            page_q     <= '0;
            page_vld_q <= 1'b0;
            rr_q       <= '0;
            error_q    <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            gch_q      <= gch_d;
            opw_q      <= opw_d;
            addr_q     <= addr_d;
            page_q     <= page_d;
            page_vld_q <= page_vld_d;
            rr_q       <= rr_d;
            error_q    <= error_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic. resp/rdata are computed one cycle ahead so that the
    // registered versions line up with the beat they describe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        gch_d      = gch_q;
        opw_d      = opw_q;
        addr_d     = addr_q;
        page_d     = page_q;
        page_vld_d = page_vld_q;
        rr_d       = rr_q;
        error_d    = error_q;
        resp_d     = '0;
        rdata_d    = '0;
        mem_we     = 1'b0;
        found      = 1'b0;
        cand       = '0;
        pick       = '0;
        req_addr   = '0;
        req_page   = '0;
        rd_beat    = '0;

        case (state_q)
            IDLE: begin
                error_d = error_q | (read & write);
                // Round-robin search starting at the pointer.
                for (int i = 0; i < NUM_CH; i++) begin
                    cand = CH_W'((int'(rr_q) + i) % NUM_CH);
                    if (!found && (read[cand] ^ write[cand]) && !error_q[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                req_addr = addr[int'(pick)*32 +: 32];
                req_page = req_addr[31:PG_SH];
                if (found) begin
                    gch_d      = pick;
                    opw_d      = write[pick];
                    addr_d     = req_addr;
                    cnt_d      = (page_vld_q && (page_q == req_page))
                                 ? CNT_W'(DELAY_PAGE_HIT - 1) : CNT_W'(DELAY_MEM - 1);
                    page_d     = req_page;
                    page_vld_d = 1'b1;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (viol) begin
                    error_d[gch_q] = 1'b1;
                    page_vld_d     = 1'b0;
                    state_d        = IDLE;
                end else if (cnt_q == '0) begin
                    state_d        = BURST;
                    beat_d         = '0;
                    resp_d[gch_q]  = 1'b1;
                    rd_beat        = '0;
                    rdata_d        = opw_q ? '0 : line_rd[int'(rd_beat)*BW +: BW];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            BURST: begin
                if (viol) begin
                    error_d[gch_q] = 1'b1;
                    page_vld_d     = 1'b0;
                    state_d        = IDLE;
                end else begin
                    mem_we = opw_q;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = TURN;
                        rr_d    = (gch_q == CH_W'(NUM_CH - 1)) ? '0 : gch_q + 1'b1;
                    end else begin
                        beat_d        = beat_q + 1'b1;
                        rd_beat       = beat_q + 1'b1;
                        resp_d[gch_q] = 1'b1;
                        rdata_d       = opw_q ? '0 : line_rd[int'(rd_beat)*BW +: BW];
                    end
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
